// File: rtl/prod_bcd_pkg.sv
// Shared types and constants for the product-to-BCD converter.
package prod_bcd_pkg;

   localparam int unsigned WIDTH_DEF  = 6;
   localparam int unsigned PROD_W_DEF = 2 * WIDTH_DEF;
   localparam int unsigned DIGITS_DEF = 4;

   localparam logic [3:0] BCD_BLANK = 4'hF;

   typedef enum logic [1:0] {
      StIdle,
      StConv,
      StDone
   } state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/prod_bcd_conv.sv
// Two's-complement product to sign + packed BCD, one bit per clock (double dabble).
// Define PROD_BCD_LEADING_BLANK_EN to replace leading zero digits with the blank code.
module prod_bcd_conv
   import prod_bcd_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned PROD_W = 2 * WIDTH,
   parameter int unsigned DIGITS = DIGITS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PROD_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  out_sign,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int unsigned CntW = clog2(PROD_W);
   localparam int unsigned BcdW = 4 * DIGITS;

   state_e            state_q, state_d;
   logic [PROD_W-1:0] mag_q, mag_d;
   logic [BcdW-1:0]   bcd_q, bcd_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              sign_q, sign_d;
   logic              res_sign_q, res_sign_d;
   logic [BcdW-1:0]   res_bcd_q, res_bcd_d;
   logic [BcdW-1:0]   bcd_adj;
   logic              accept;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (bcd_q[4*i +: 4]),
         .digit_o (bcd_adj[4*i +: 4])
      );
   end

   assign in_ready = !rst && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d    = state_q;
      mag_d      = mag_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      sign_d     = sign_q;
      res_sign_d = res_sign_q;
      res_bcd_d  = res_bcd_q;
      unique case (state_q)
         StIdle: ;
         StConv: begin
            bcd_d = {bcd_adj[BcdW-2:0], mag_q[PROD_W-1]};
            mag_d = {mag_q[PROD_W-2:0], 1'b0};
            cnt_d = cnt_q + CntW'(1);
            // Results become visible only once the last bit has been shifted in.
            if (cnt_q == CntW'(PROD_W - 1)) begin
               state_d    = StDone;
               res_sign_d = sign_q;
               res_bcd_d  = bcd_d;
            end
         end
         StDone: if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (accept) begin
         sign_d  = in_data[PROD_W-1];
         // Most-negative input wraps to 2^(PROD_W-1), which is the correct unsigned magnitude.
         mag_d   = in_data[PROD_W-1] ? (~in_data + {{(PROD_W-1){1'b0}}, 1'b1}) : in_data;
         bcd_d   = '0;
         cnt_d   = '0;
         state_d = StConv;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         mag_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         res_sign_q <= 1'b0;
         res_bcd_q  <= '0;
      end else begin
         state_q    <= state_d;
         mag_q      <= mag_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         sign_q     <= sign_d;
         res_sign_q <= res_sign_d;
         res_bcd_q  <= res_bcd_d;
      end
   end

   assign out_valid = (state_q == StDone);
   assign out_sign  = res_sign_q;

`ifdef PROD_BCD_LEADING_BLANK_EN
   always_comb begin
      logic lead;
      out_bcd = res_bcd_q;
      lead    = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         if (lead && (res_bcd_q[4*i +: 4] == 4'd0)) out_bcd[4*i +: 4] = BCD_BLANK;
         else lead = 1'b0;
      end
   end
`else
   assign out_bcd = res_bcd_q;
`endif

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Scoreboard bench for prod_bcd_conv: directed plan items plus randomized traffic.
module tb_prod_bcd_conv;

   localparam int PW = 12;
   localparam int ND = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [PW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          out_sign;
   logic [4*ND-1:0] out_bcd;
   logic          out_valid;
   logic          out_ready;

   int checks   = 0;
   int failures = 0;
   logic [4*ND:0] sb[$];
   bit stall_q = 1'b0;
   logic [4*ND:0] held;
   bit done_rand = 1'b0;

   always #5 clk = ~clk;

   prod_bcd_conv dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_sign  (out_sign),
      .out_bcd   (out_bcd),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Expected {sign, bcd} computed with plain decimal arithmetic.
   function automatic logic [4*ND:0] model(input logic [PW-1:0] d);
      int v, m, p;
      logic [4*ND-1:0] b;
      bit lead;
      v = int'($signed(d));
      m = (v < 0) ? -v : v;
      p = 1;
      for (int k = 0; k < ND; k++) begin
         b[4*k +: 4] = 4'((m / p) % 10);
         p = p * 10;
      end
`ifdef PROD_BCD_LEADING_BLANK_EN
      lead = 1'b1;
      for (int k = ND - 1; k >= 1; k--) begin
         if (lead && b[4*k +: 4] == 4'd0) b[4*k +: 4] = 4'hF;
         else lead = 1'b0;
      end
`else
      lead = 1'b0;
`endif
      return {(v < 0), b};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [PW-1:0] d);
      int n;
      n = 0;
      in_data  = d;
      in_valid = 1'b1;
      #1;
      while (!in_ready && n < 200) begin
         step();
         #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready got 0 expected 1 for data %h", d);
      end else begin
         sb.push_back(model(d));
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         step();
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: pending got %0d expected 0", sb.size());
      end
   endtask

   // Monitor: compares each delivered result and checks DONE outputs hold while stalled.
   initial begin
      logic [4*ND:0] exp;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_q = 1'b0;
         end else begin
            if (stall_q) begin
               check("hold_valid", 32'(out_valid), 32'd1);
               check("hold_data", 32'({out_sign, out_bcd}), 32'(held));
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output: got %h expected none", {out_sign, out_bcd});
               end else begin
                  exp = sb.pop_front();
                  check("result", 32'({out_sign, out_bcd}), 32'(exp));
               end
            end
            stall_q = out_valid && !out_ready;
            held    = {out_sign, out_bcd};
         end
      end
   end

   initial begin
      int lat;
      logic [PW-1:0] d;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      step();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sign", 32'(out_sign), 32'd0);
      check("rst_bcd", 32'(out_bcd), 32'd0);
      step();
      rst = 1'b0;
      #1;
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // Zero input with latency measurement.
      send(12'h000);
      wait_valid(lat);
      check("latency_zero", 32'(lat), 32'd12);
      out_ready = 1'b1;
      step();

      send(12'h3C1);
      send(12'hC3F);
      send(12'h800);
      drain();

      // Back-pressure then zero-bubble accept.
      out_ready = 1'b0;
      send(12'h3C1);
      wait_valid(lat);
      repeat (5) begin
         step();
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_data   = 12'h019;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check("bb_in_ready", 32'(in_ready), 32'd1);
      sb.push_back(model(12'h019));
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("bb_conv_valid", 32'(out_valid), 32'd0);
      wait_valid(lat);
      check("latency_bb", 32'(lat), 32'd12);
      out_ready = 1'b1;
      drain();

      // Reset in the middle of a conversion.
      send(12'h3C1);
      repeat (4) step();
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sign", 32'(out_sign), 32'd0);
      check("mid_rst_bcd", 32'(out_bcd), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      sb.delete();
      step();
      step();
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      send(12'hFFF);
      drain();

      // Randomized traffic with random consumer back-pressure.
      fork
         begin
            for (int t = 0; t < 150; t++) begin
               case ($urandom_range(0, 7))
                  0: d = 12'h000;
                  1: d = 12'h800;
                  2: d = 12'h7FF;
                  3: d = 12'hFFF;
                  default: d = 12'($urandom);
               endcase
               repeat ($urandom_range(0, 3)) step();
               send(d);
            end
            done_rand = 1'b1;
         end
         begin
            while (!done_rand) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
